// File: rtl/som_serial_param_if.sv
// Start/busy/done handshake bundle for som_serial_param.
// The ovf signal exists only when SOM_OVF_FLAG_EN is defined.
interface som_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] A;
    logic             Cout;
`ifdef SOM_OVF_FLAG_EN
    logic             ovf;

    modport master (output start, sub, x, y, Cin, input busy, done, A, Cout, ovf);
    modport slave  (input start, sub, x, y, Cin, output busy, done, A, Cout, ovf);
`else
    modport master (output start, sub, x, y, Cin, input busy, done, A, Cout);
    modport slave  (input start, sub, x, y, Cin, output busy, done, A, Cout);
`endif
endinterface

// File: rtl/som_serial_param.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSB first, WIDTH/DIGIT cycles per op.
// Optional signed-overflow flag (ovf) enabled by defining SOM_OVF_FLAG_EN.
module som_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    som_serial_param_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT:0]   digitSum_d;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] acc_d;
    logic             carry_d;
    logic             lastDigit_d;
    logic             accept_d;

`ifdef SOM_OVF_FLAG_EN
    logic             ovf_q;
    logic             ovf_d;
`endif

    // One digit of the ripple add; the new digit enters the result from the MSB end.
    always_comb begin
        digitSum_d  = {1'b0, x_q[DIGIT-1:0]} + {1'b0, y_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
        carry_d     = digitSum_d[DIGIT];
        x_d         = x_q >> DIGIT;
        y_d         = y_q >> DIGIT;
        acc_d       = (acc_q >> DIGIT)
                    | (WIDTH'(digitSum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
        lastDigit_d = (cnt_q == CNT_W'(N - 1));
        accept_d    = bus.start && ((state_q == IDLE) || (state_q == DONE));
    end

`ifdef SOM_OVF_FLAG_EN
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    always_comb begin
        ovf_d = (x_q[DIGIT-1] ^ y_q[DIGIT-1] ^ digitSum_d[DIGIT-1]) ^ carry_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SOM_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        // Subtraction is x + ~y + 1, so borrow-in flips to carry-in.
                        x_q     <= bus.x;
                        y_q     <= bus.sub ? ~bus.y : bus.y;
                        carry_q <= bus.Cin ^ bus.sub;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (lastDigit_d) begin
                        a_q     <= acc_d;
                        cout_q  <= carry_d;
`ifdef SOM_OVF_FLAG_EN
                        ovf_q   <= ovf_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.A    = a_q;
    assign bus.Cout = cout_q;
`ifdef SOM_OVF_FLAG_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
